// File: rtl/qu_common.sv
// ============================================================================
// Module      : qu_common
// Description : Shared types and constants for the front-end pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qu_common;

    typedef logic [31:0] pc_t;

    typedef struct packed {
        pc_t         pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam pc_t FETCH_PC_INCR = 32'd4;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : Power-of-two FIFO of fetched {pc, instr} entries with flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
    import qu_common::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Flush wins over push/pop; a pop on an empty queue is a no-op.
    assign w_push = push && !flush && !rst;
    assign w_pop  = pop && !flush && !rst && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

`ifndef SYNTHESIS
    // Upstream credit accounting must never let a push land on a full queue.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(push && (r_count == DEPTH_C)));
        end
    end
`endif

    assign head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch.sv
// ============================================================================
// Module      : fetch
// Description : Instruction fetch stage: PC, credit-gated imem requests,
//               in-flight tracking and output queue towards decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch
    import qu_common::*;
#(
    parameter int  INSTR_WIDTH = 32,
    parameter pc_t RESET_PC    = 32'h0000_0000,
    parameter int  QUEUE_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output pc_t                    imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect_valid,
    input  pc_t                    redirect_pc,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output pc_t                    pc_out,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int            CW      = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(QUEUE_DEPTH);

    pc_t  r_fetch_pc;
    logic r_inflight;
    pc_t  r_inflight_pc;
    logic r_inflight_kill;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_credits_used;
    logic          w_issue;
    logic          w_accept;
    logic          w_push;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;

    // Queued entries plus the outstanding response must leave a free slot.
    assign w_credits_used = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue        = !rst && !redirect_valid && (w_credits_used < DEPTH_C);
    assign w_accept       = w_issue && imem_ready;

    assign imem_req  = w_issue;
    assign imem_addr = r_fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc      <= RESET_PC;
            r_inflight      <= 1'b0;
            r_inflight_pc   <= '0;
            r_inflight_kill <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc      <= redirect_pc & ~32'h3;
            r_inflight      <= 1'b0;
            r_inflight_kill <= 1'b1;
        end else if (w_accept) begin
            r_fetch_pc      <= r_fetch_pc + FETCH_PC_INCR;
            r_inflight      <= 1'b1;
            r_inflight_pc   <= r_fetch_pc;
            r_inflight_kill <= 1'b0;
        end else begin
            r_inflight      <= 1'b0;
        end
    end

    assign w_push             = r_inflight && !r_inflight_kill && !redirect_valid && !rst;
    assign w_push_entry.pc    = r_inflight_pc;
    assign w_push_entry.instr = imem_rdata;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (out_valid && out_ready),
        .head      (w_head),
        .count     (w_count)
    );

    assign out_valid = (w_count != '0);
    assign instr_out = w_head.instr;
    assign pc_out    = w_head.pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch.sv
// ============================================================================
// Module      : tb_fetch
// Description : Directed + random bench for fetch with an in-order scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_pc = RESET_PC;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    fetch #(
        .INSTR_WIDTH (32),
        .RESET_PC    (RESET_PC),
        .QUEUE_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    // Memory answers exactly one cycle after an accepted request.
    always @(posedge clk) begin
        imem_rdata <= (imem_req && imem_ready) ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Per-cycle scoreboard update; called just before the rising edge.
    task automatic monitor();
        logic [63:0] e;
        if (rst === 1'b1) begin
            sb.delete();
            exp_pc = RESET_PC;
        end else begin
            if (redirect_valid === 1'b1) check("req_during_redirect", {31'b0, imem_req}, 32'd0);
            if (imem_req === 1'b1) check("imem_addr", imem_addr, exp_pc);
            if (imem_req === 1'b1 && imem_ready === 1'b1) begin
                sb.push_back({exp_pc, mem_word(exp_pc)});
                exp_pc = exp_pc + 32'd4;
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                check("sb_has_entry", {31'b0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("pc_out", pc_out, e[63:32]);
                    check("instr_out", instr_out, e[31:0]);
                end
            end
            if (redirect_valid === 1'b1) begin
                sb.delete();
                exp_pc = redirect_pc & ~32'h3;
            end
        end
    endtask

    task automatic drive(input logic r, input logic rv, input logic [31:0] rpc,
                         input logic ir, input logic orr);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ready     = ir;
        out_ready      = orr;
        #1;
    endtask

    task automatic tick();
        monitor();
        @(negedge clk);
    endtask

    initial begin
        // Power-up reset and reset state
        repeat (2) begin drive(1, 0, 0, 1, 1); tick(); end
        drive(1, 0, 0, 1, 1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_instr_out", instr_out, 32'd0);
        tick();

        // Streaming: first request in first cycle out of reset, data at +2
        drive(0, 0, 0, 1, 1);
        check("c0_imem_req", {31'b0, imem_req}, 32'd1);
        check("c0_imem_addr", imem_addr, 32'h100);
        check("c0_out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        drive(0, 0, 0, 1, 1);
        check("c1_out_valid", {31'b0, out_valid}, 32'd0);
        check("c1_imem_addr", imem_addr, 32'h104);
        tick();
        drive(0, 0, 0, 1, 1);
        check("c2_out_valid", {31'b0, out_valid}, 32'd1);
        check("c2_pc_out", pc_out, 32'h100);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 1);
            check("stream_out_valid", {31'b0, out_valid}, 32'd1);
            tick();
        end

        // Long stall fills exactly QUEUE_DEPTH entries, then release
        drive(1, 0, 0, 1, 1); tick();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 1, 0);
            if (i >= 4) check("stall_imem_req", {31'b0, imem_req}, 32'd0);
            tick();
        end
        drive(0, 0, 0, 1, 1);
        check("stall_head_pc", pc_out, 32'h100);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 1);
            check("release_out_valid", {31'b0, out_valid}, 32'd1);
            tick();
        end

        // Redirect with three queued entries and one in flight
        drive(1, 0, 0, 1, 1); tick();
        for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 1, 0); tick(); end
        drive(0, 1, 32'h203, 1, 0);
        check("redir_imem_req", {31'b0, imem_req}, 32'd0);
        tick();
        drive(0, 0, 0, 1, 1);
        check("redir_n1_out_valid", {31'b0, out_valid}, 32'd0);
        check("redir_n1_imem_req", {31'b0, imem_req}, 32'd1);
        check("redir_n1_imem_addr", imem_addr, 32'h200);
        tick();
        drive(0, 0, 0, 1, 1);
        check("redir_n2_out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        drive(0, 0, 0, 1, 1);
        check("redir_n3_out_valid", {31'b0, out_valid}, 32'd1);
        check("redir_n3_pc_out", pc_out, 32'h200);
        tick();

        // Redirect in the same cycle as a pop of head 0x104
        drive(1, 0, 0, 1, 1); tick();
        repeat (2) begin drive(0, 0, 0, 1, 0); tick(); end
        drive(0, 0, 0, 1, 1);
        check("rp_head0", pc_out, 32'h100);
        tick();
        drive(0, 1, 32'h300, 1, 1);
        check("rp_head1", pc_out, 32'h104);
        tick();
        drive(0, 0, 0, 1, 1);
        check("rp_n1_out_valid", {31'b0, out_valid}, 32'd0);
        check("rp_n1_imem_addr", imem_addr, 32'h300);
        tick();
        drive(0, 0, 0, 1, 1); tick();
        drive(0, 0, 0, 1, 1);
        check("rp_n3_pc_out", pc_out, 32'h300);
        tick();

        // Random memory back-pressure and consumer stalls
        for (int i = 0; i < 200; i++) begin
            drive(0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end

        // PC wrap at the top of the address space
        drive(0, 1, 32'hFFFF_FFFC, 1, 1); tick();
        drive(0, 0, 0, 1, 1);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        drive(0, 0, 0, 1, 1);
        check("wrap_addr1", imem_addr, 32'h0000_0000);
        tick();
        repeat (8) begin drive(0, 0, 0, 1, 0); tick(); end
        drive(0, 0, 0, 1, 0);
        check("full_imem_req", {31'b0, imem_req}, 32'd0);
        check("full_head_pc", pc_out, 32'hFFFF_FFFC);
        tick();

        // Reset with a full queue
        drive(1, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 1, 1);
        check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_mid_imem_addr", imem_addr, RESET_PC);
        check("rst_mid_imem_req", {31'b0, imem_req}, 32'd1);
        tick();
        repeat (4) begin drive(0, 0, 0, 1, 1); tick(); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch.md
# fetch

Instruction fetch stage: owns the architectural fetch PC, issues sequential word requests to instruction memory and buffers returned instructions with their PCs in a small queue. It sits directly upstream of `decode` and drives its `instr_in`/`pc_in` through a valid/ready handshake. Redirects from branch/jump resolution reload the PC and discard all younger fetched or in-flight instructions.

## Interface
- `INSTR_WIDTH`, 32, instruction word width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- `QUEUE_DEPTH`, 4, output queue entries; power of two, ≥2. Full throughput requires ≥3.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: request valid.
- `imem_addr` out pc_t: word-aligned request address.
- `imem_ready` in 1: memory accepts request this cycle.
- `imem_rdata` in INSTR_WIDTH: instruction, valid exactly 1 cycle after an accepted request.
- `redirect_valid` in 1: flush and reload PC.
- `redirect_pc` in pc_t: new fetch address; bits [1:0] ignored (forced 0).
- `instr_out` out INSTR_WIDTH: to `decode.instr_in`.
- `pc_out` out pc_t: to `decode.pc_in`.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: consumer takes head entry.

## Operation
- Registers: `fetch_pc`, `inflight` (1 bit), `inflight_pc`, `inflight_kill`, queue storage, read/write pointers, `count` (0..QUEUE_DEPTH).
- Issue condition: `!rst && !redirect_valid && (count + inflight) < QUEUE_DEPTH`. `imem_req` = issue condition; `imem_addr` = `fetch_pc`.
- Accept (`imem_req && imem_ready`): `fetch_pc <= fetch_pc + 4` (32-bit wrap, 0xFFFF_FFFC → 0), `inflight <= 1`, `inflight_pc <= fetch_pc`, `inflight_kill <= 0`. No accept: `inflight <= 0`.
- Response: in the cycle after an accept, if `inflight && !inflight_kill && !redirect_valid`, push {`inflight_pc`, `imem_rdata`} into queue.
- Pop: `out_valid && out_ready` advances read pointer. Push and pop in same cycle: `count` unchanged, both pointers advance; pop of the only entry while pushing is legal.
- Queue never overflows: credit check guarantees space; pushing into full queue is an assertion failure.
- Redirect (`redirect_valid`=1): `fetch_pc <= {redirect_pc[31:2],2'b00}`; queue emptied (pointers, `count` ← 0); any response arriving that cycle dropped; `inflight_kill <= 1` is irrelevant because no request issues during redirect, so `inflight <= 0`. Pop in the same cycle counts as delivered (decode already sampled it); the rest are discarded.
- Back-to-back redirects: last one wins; fetch resumes the cycle after `redirect_valid` drops.
- `out_valid` = `count != 0`; `instr_out`/`pc_out` = head entry; when empty, outputs hold 0.

## Timing
- Reset values: `fetch_pc`=RESET_PC, `count`=0, `inflight`=0, pointers=0; outputs `imem_req`=0, `imem_addr`=RESET_PC, `out_valid`=0, `instr_out`=0, `pc_out`=0.
- Reset mid-operation: queue and in-flight response discarded, same as power-up; `rst` dominates `redirect_valid`.
- Latency: request accepted at cycle N → entry visible at `out_valid` in N+2 (no bypass).
- First request issues in the first cycle `rst`=0.
- Redirect at cycle N → request to new PC at N+1, `out_valid` for it at N+3 earliest; `out_valid`=0 at N+1 and N+2.
- Sustained 1 instr/cycle with `out_ready`=1, `imem_ready`=1, QUEUE_DEPTH≥3.
- `out_ready`=0 for long stall: exactly QUEUE_DEPTH entries buffered, then `imem_req`=0; no instruction lost or duplicated.
- `imem_ready`=0: `fetch_pc` holds, `imem_req` stays 1.

## Structure
- `qu_common`: add `fetch_entry_t` {pc_t pc; logic [31:0] instr}, `FETCH_PC_INCR` = 4; reuse existing `pc_t`.
- One sub-module: `fetch_queue` (parameterised FIFO of `fetch_entry_t`, push/pop/flush, count output, synchronous active-high reset). `fetch` holds PC, in-flight tracking and credit logic.

## Test plan
- Reset, RESET_PC=0x100, memory returns addr-derived words, `out_ready`=1 → `imem_addr` 0x100,0x104,…; first `out_valid` cycle 2 with pc_out=0x100; then one entry per cycle, in order.
- `out_ready`=0 for 10 cycles → exactly 4 entries (0x100–0x10C) buffered, `imem_req`=0 after credits exhausted; release → 0x100..0x10C delivered then 0x110 with no gap/duplicate.
- Redirect to 0x203 with 3 queued entries and one in flight → `out_valid`=0 next two cycles, next request 0x200, first delivered pc_out=0x200; stale in-flight word never appears.
- Redirect and pop of head (pc 0x104) in same cycle → 0x104 counted delivered, 0x108+ discarded.
- `imem_ready` toggled randomly for 200 cycles, `out_ready` random → delivered PC sequence strictly +4, instr matches memory model.
- `fetch_pc`=0xFFFF_FFFC → next request 0x0000_0000; `rst` asserted with full queue → next cycle `out_valid`=0, `imem_addr`=RESET_PC.
